// File: rtl/bram_check.sv
// bram_check: fills an inferred BRAM with a seeded pattern, reads it back through the
// registered read port and reports mismatches. Define BRAM_CHECK_INV_PASS_EN for a second, inverted pass.
module bram_check #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              hw_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] seed,
   input  logic              inject_en,
   input  logic [ADDR_W-1:0] inject_addr,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic              io0
);

   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_READ,
      S_DRAIN,
      S_DONE
`ifdef BRAM_CHECK_INV_PASS_EN
      , S_INV_SETUP
`endif
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] inject_addr_q;
   logic [DATA_W-1:0] seed_q;
   logic              inject_en_q;
   logic              rd_valid;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] cmp_data;
   logic [DATA_W-1:0] pat_mask;
   logic              mismatch;
   logic [7:0]        err_next;
   logic              run_clean;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

`ifdef BRAM_CHECK_INV_PASS_EN
   logic inv_q;
   assign pat_mask = {DATA_W{inv_q}};
`else
   assign pat_mask = '0;
`endif

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] s);
      return DATA_W'(a) ^ s;
   endfunction

   always_comb begin
      wr_data = pattern(addr, seed_q) ^ pat_mask;
      if (inject_en_q && (addr == inject_addr_q))
         wr_data = ~wr_data;
   end

   // rd_valid lags READ by one cycle, so the stale first READ cycle is skipped and DRAIN compares the last word
   assign cmp_data  = pattern(addr_d, seed_q) ^ pat_mask;
   assign mismatch  = rd_valid && (rdata != cmp_data);
   assign err_next  = (mismatch && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
   assign run_clean = (err_next == 8'd0);

   always_ff @(posedge hw_clk) begin
      if (state == S_FILL)
         mem[addr] <= wr_data;
      if (state == S_READ)
         rdata <= mem[addr];
   end

   always_ff @(posedge hw_clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         addr            <= '0;
         addr_d          <= '0;
         inject_addr_q   <= '0;
         seed_q          <= '0;
         inject_en_q     <= 1'b0;
         rd_valid        <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_fail_addr <= '0;
         io0             <= 1'b0;
`ifdef BRAM_CHECK_INV_PASS_EN
         inv_q           <= 1'b0;
`endif
      end else begin
         rd_valid <= 1'b0;
         addr_d   <= addr;
         if (mismatch) begin
            if (err_count == 8'd0)
               first_fail_addr <= addr_d;
            err_count <= err_next;
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  seed_q          <= seed;
                  inject_en_q     <= inject_en;
                  inject_addr_q   <= inject_addr;
                  err_count       <= '0;
                  first_fail_addr <= '0;
                  pass            <= 1'b0;
                  io0             <= 1'b0;
                  done            <= 1'b0;
                  busy            <= 1'b1;
                  addr            <= '0;
                  state           <= S_FILL;
`ifdef BRAM_CHECK_INV_PASS_EN
                  inv_q           <= 1'b0;
`endif
               end
            end
            S_FILL: begin
               addr <= addr + 1'b1;
               if (addr == LAST_ADDR)
                  state <= S_READ;
            end
            S_READ: begin
               rd_valid <= 1'b1;
               addr     <= addr + 1'b1;
               if (addr == LAST_ADDR)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
`ifdef BRAM_CHECK_INV_PASS_EN
               if (!inv_q)
                  state <= S_INV_SETUP;
               else
`endif
               begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= run_clean;
                  io0   <= run_clean;
               end
            end
`ifdef BRAM_CHECK_INV_PASS_EN
            // one turnaround cycle so the inverted mask is settled before the second fill
            S_INV_SETUP: begin
               inv_q <= 1'b1;
               state <= S_FILL;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_check.sv
// Randomized self-checking bench for bram_check against a behavioural run model.
module tb_bram_check;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int D      = 1 << ADDR_W;
`ifdef BRAM_CHECK_INV_PASS_EN
   localparam int NPASS    = 2;
   localparam int DONE_LIT = 1028;
`else
   localparam int NPASS    = 1;
   localparam int DONE_LIT = 514;
`endif
   localparam int DONE_AT = NPASS * (2 * D + 2);

   logic              hw_clk;
   logic              rst;
   logic              start;
   logic [DATA_W-1:0] seed;
   logic              inject_en;
   logic [ADDR_W-1:0] inject_addr;
   logic              busy;
   logic              done;
   logic              pass;
   logic [7:0]        err_count;
   logic [ADDR_W-1:0] first_fail_addr;
   logic              io0;

   bram_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .hw_clk(hw_clk),
      .rst(rst),
      .start(start),
      .seed(seed),
      .inject_en(inject_en),
      .inject_addr(inject_addr),
      .busy(busy),
      .done(done),
      .pass(pass),
      .err_count(err_count),
      .first_fail_addr(first_fail_addr),
      .io0(io0)
   );

   initial hw_clk = 1'b0;
   always #5 hw_clk = ~hw_clk;

   int vectors = 0;
   int miscompares = 0;
   bit checking = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // model: cycle index inside the current run (-1 = idle after reset) and predicted results
   int        m_cyc = -1;
   logic [7:0] m_seed;
   logic       m_inj;
   logic [7:0] m_ia;
   int         m_err;
   int         m_ffa;
   logic       m_pass;

   task automatic model_compute();
      logic [DATA_W-1:0] ram [D];
      logic [DATA_W-1:0] v;
      m_err = 0;
      m_ffa = 0;
      for (int p = 0; p < NPASS; p++) begin
         for (int a = 0; a < D; a++) begin
            v = DATA_W'(a) ^ m_seed;
            if (p == 1) v = ~v;
            ram[a] = (m_inj && a == int'(m_ia)) ? ~v : v;
         end
         for (int a = 0; a < D; a++) begin
            v = DATA_W'(a) ^ m_seed;
            if (p == 1) v = ~v;
            if (ram[a] != v) begin
               if (m_err == 0) m_ffa = a;
               if (m_err < 255) m_err++;
            end
         end
      end
      m_pass = (m_err == 0);
   endtask

   always @(posedge hw_clk or posedge rst) begin
      if (rst) begin
         m_cyc = -1;
      end else if ((m_cyc == -1 || m_cyc >= DONE_AT) && start === 1'b1) begin
         m_seed = seed;
         m_inj  = inject_en;
         m_ia   = inject_addr;
         model_compute();
         m_cyc = 1;
      end else if (m_cyc >= 1) begin
         m_cyc++;
      end
   end

   always @(negedge hw_clk) begin
      if (checking) begin
         if (m_cyc == -1) begin
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_pass", pass, 0);
            check("idle_err", err_count, 0);
            check("idle_ffa", first_fail_addr, 0);
            check("idle_io0", io0, 0);
         end else begin
            check("busy", busy, (m_cyc < DONE_AT) ? 1 : 0);
            check("done", done, (m_cyc >= DONE_AT) ? 1 : 0);
            if (m_cyc >= DONE_AT) begin
               check("pass", pass, m_pass);
               check("err_count", err_count, m_err);
               check("first_fail_addr", first_fail_addr, m_ffa);
               check("io0", io0, m_pass);
            end
         end
      end
   end

   task automatic do_run(input logic [7:0] s, input logic ie, input logic [7:0] ia,
                         input int lit_err, input int lit_ffa, input int lit_pass, input int poke_at);
      @(posedge hw_clk); #1;
      seed = s; inject_en = ie; inject_addr = ia; start = 1'b1;
      @(posedge hw_clk); #1;
      start = 1'b0;
      seed = 8'($urandom); inject_en = 1'($urandom); inject_addr = 8'($urandom);
      for (int n = 0; n < 3000; n++) begin
         start = (m_cyc == poke_at) ? 1'b1 : 1'b0;
         if (start) seed = 8'($urandom);
         @(negedge hw_clk);
         if (done === 1'b1) break;
         @(posedge hw_clk); #1;
      end
      start = 1'b0;
      check("done_cycle", m_cyc, DONE_LIT);
      if (lit_err >= 0) check("lit_err_count", err_count, lit_err);
      if (lit_ffa >= 0) check("lit_first_fail_addr", first_fail_addr, lit_ffa);
      if (lit_pass >= 0) begin
         check("lit_pass", pass, lit_pass);
         check("lit_io0", io0, lit_pass);
      end
      $display("run seed=%02h inj=%0d addr=%02h -> pass=%0d err=%0d ffa=%02h",
               s, ie, ia, pass, err_count, first_fail_addr);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; seed = '0; inject_en = 1'b0; inject_addr = '0;
      #2 rst = 1'b1;
      #1 checking = 1'b1;
      repeat (3) @(posedge hw_clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err_count, 0);
      rst = 1'b0;

      do_run(8'h5A, 1'b0, 8'h00, 0, 0, 1, -1);
      do_run(8'h00, 1'b1, 8'h03, NPASS, 3, 0, -1);
      do_run(8'($urandom), 1'b1, 8'hFF, NPASS, 255, 0, -1);
      do_run(8'($urandom), 1'b1, 8'h00, NPASS, 0, 0, -1);
      do_run(8'h5A, 1'b0, 8'h00, 0, 0, 1, 100);
      do_run(8'hFF, 1'b0, 8'h00, 0, 0, 1, -1);

      // mid-run reset at cycle 300
      @(posedge hw_clk); #1;
      seed = 8'h33; inject_en = 1'b1; inject_addr = 8'h10; start = 1'b1;
      @(posedge hw_clk); #1;
      start = 1'b0;
      for (int n = 0; n < 400 && m_cyc != 300; n++) begin
         @(posedge hw_clk); #1;
      end
      check("reached_cycle_300", m_cyc, 300);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      @(posedge hw_clk); #1;
      rst = 1'b0;
      do_run(8'($urandom), 1'b0, 8'($urandom), 0, 0, 1, -1);

      for (int r = 0; r < 4; r++)
         do_run(8'($urandom), 1'($urandom), 8'($urandom), -1, -1, -1,
                int'($urandom_range(1, DONE_AT - 1)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/bram_check.md
# bram_check

Read-back checker for the inferred 256×8 block RAM on the VSDSquadron FM iCE40 design. On `start` it fills its own inferred BRAM with a seeded pattern. It then reads every location back through the registered (1-cycle) read port and compares against the regenerated pattern. It reports pass/fail, a saturating error count and the first failing address, proving BRAM inference and read timing in hardware.

## Interface
- `ADDR_W`, 8, address width; depth = 2^ADDR_W
- `DATA_W`, 8, data width; must be ≥ ADDR_W

Ports:
- `hw_clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE or DONE
- `seed`  in  DATA_W  pattern seed; captured on accepted `start`
- `inject_en`  in  1  fault injection enable; captured on accepted `start`
- `inject_addr`  in  ADDR_W  location written with the inverted pattern when fault injection is enabled; captured on accepted `start`
- `busy`  out  1  high from the cycle after `start` until `done`
- `done`  out  1  level; high after a run until the next accepted `start`
- `pass`  out  1  valid while `done`; 1 = zero mismatches
- `err_count`  out  8  mismatches, saturating at 255
- `first_fail_addr`  out  ADDR_W  address of the first mismatch; 0 if none
- `io0`  out  1  `done & pass`; keeps the logic from being optimised away

## Operation
- Pattern: `exp(a) = zero_extend(a) ^ seed_q`.
- RAM: a single `reg [DATA_W-1:0] mem [0:2^ADDR_W-1]`.
  - One write port and one registered read port, both on `hw_clk`.
  - No reset on the array, no initial block.
  - Read and write never occur in the same cycle.
- FSM states: IDLE → FILL → READ → DRAIN → DONE (→ FILL on `start`).
  - IDLE/DONE: `start`=1 captures `seed_q`, `inject_en_q` and `inject_addr_q`, clears `err_count`, `first_fail_addr` and `pass`, sets `addr`=0 and moves to FILL.
  - FILL: writes `mem[addr] <= exp(addr)`. If `inject_en_q` is set and `addr==inject_addr_q`, it writes `~exp(addr)` instead. `addr` increments each cycle; after the last address it wraps to 0 and the FSM enters READ.
  - READ: each cycle issues read address `addr` and registers it as `addr_d`. From the second READ cycle on, it compares `rdata` against `exp(addr_d)`. After the last address it enters DRAIN.
  - DRAIN: compares the final location, then enters DONE.
  - DONE: sets `pass = (err_count==0)`.
- On mismatch:
  - If `err_count==0`, `first_fail_addr <= addr_d`.
  - `err_count` increments and saturates at 255.
- `start` while `busy` is ignored.
- Outputs after reset:
  - `busy`, `done`, `pass`, `io0` = 0.
  - `err_count` and `first_fail_addr` = 0.
  - FSM = IDLE, `addr` = 0.

## Timing
- The cycle in which `start` is sampled is cycle 0.
- `busy` is high from cycle 1. FILL covers cycles 1..D, where D = 2^ADDR_W.
- READ covers cycles D+1..2D. DRAIN is cycle 2D+1.
- In the cycle after DRAIN, `done`=1, `busy`=0 and `pass` is valid. The default build reaches this at cycle 2D+2 = 514.
- Read latency is exactly 1 cycle. The compare in cycle t uses the address issued in cycle t-1.
- `rst` mid-run returns the block to IDLE immediately and clears all outputs.
  - RAM contents are undefined after a mid-run reset; no assumption is made about them.
  - A following `start` runs normally.
- Address counter wrap: 2^ADDR_W-1 → 0. It is the only end-of-phase condition, with no separate length counter.

## Configuration
- `BRAM_CHECK_INV_PASS_EN` defined: after the first DRAIN, add phases FILL_INV → READ_INV → DRAIN_INV before DONE.
  - These phases use pattern `~exp(a)` and the same fault-injection rule, which writes `exp(a)` at the injected address.
  - Errors accumulate into the same `err_count`. `first_fail_addr` keeps the earliest failure.
  - `done` rises at cycle 4D+4 (1028).
- Macro undefined: the single pass described above is the only behaviour, and no inverted-phase logic is synthesised.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs 0, `busy`=0.
- Clean run: `seed`=0x5A, `inject_en`=0, pulse `start` → `done` at cycle 514 (1028 with INV_PASS), `pass`=1, `err_count`=0, `io0`=1.
- Single fault: `seed`=0x00, `inject_en`=1, `inject_addr`=0x03 → `pass`=0, `err_count`=1 (2 with INV_PASS), `first_fail_addr`=0x03, `io0`=0.
- Latency edge: `inject_addr`=0xFF and then 0x00 → each is reported as `first_fail_addr`. This confirms the DRAIN compare and the first-READ-cycle skip.
- Busy/restart: `start` pulsed at cycle 100 is ignored, and `done` timing is unchanged. A `start` in DONE with `seed`=0xFF starts a new run, `done` drops next cycle, and the final `pass`=1.
- Mid-run reset: assert `rst` at cycle 300 → `busy`=0 the same cycle. A new `start` then completes with `pass`=1.
